// File: rtl/dance_pkg.sv
// dance_pkg: shared lane state encoding and default widths for the step scorer.
// Optional macro STEP_STRICT_EN adds the LOCKED lane state (wrong step forfeits the window).
package dance_pkg;

    localparam int DEFAULT_CODE_W   = 3;
    localparam int DEFAULT_SCORE_W  = 8;
    localparam int DEFAULT_STREAK_W = 4;

    // Lane progress through one step window.
    typedef enum logic [1:0] {
        LANE_IDLE    = 2'b00,
        LANE_ARMED   = 2'b01,
`ifdef STEP_STRICT_EN
        LANE_MATCHED = 2'b10,
        LANE_LOCKED  = 2'b11
`else
        LANE_MATCHED = 2'b10
`endif
    } lane_state_e;

    // Outcome of evaluating a window when it closes.
    typedef struct packed {
        logic evalNow;
        logic evalHit;
    } lane_eval_t;

endpackage

// File: rtl/step_lane.sv
// step_lane: one player lane. Tracks whether the player hit the expected step
// inside the current window and keeps saturating score/streak counters.
// Optional macro STEP_STRICT_EN: a wrong step while armed locks the lane into a miss.
module step_lane
    import dance_pkg::*;
#(
    parameter int CODE_W   = DEFAULT_CODE_W,
    parameter int SCORE_W  = DEFAULT_SCORE_W,
    parameter int STREAK_W = DEFAULT_STREAK_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                win_open_i,
    input  logic                win_close_i,
    input  logic [CODE_W-1:0]   expected_i,
    input  logic [CODE_W-1:0]   step_code_i,
    input  logic                step_valid_i,
    output logic                point_o,
    output logic                hit_o,
    output logic                miss_o,
    output logic [SCORE_W-1:0]  score_o,
    output logic [STREAK_W-1:0] streak_o
);

    localparam logic [SCORE_W-1:0]  SCORE_MAX  = {SCORE_W{1'b1}};
    localparam logic [STREAK_W-1:0] STREAK_MAX = {STREAK_W{1'b1}};

    lane_state_e         state_q, state_d;
    logic                hit_q, hit_d;
    logic                miss_q, miss_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    lane_eval_t          evalRes;
    logic                stepMatch;

    assign stepMatch = step_valid_i && (step_code_i == expected_i);

    // Decide whether this cycle closes a window and, if so, whether it scores.
    always_comb begin
        evalRes = '0;
        case (state_q)
            LANE_ARMED: begin
                evalRes.evalNow = win_close_i;
                evalRes.evalHit = stepMatch;
            end
            LANE_MATCHED: begin
                evalRes.evalNow = win_close_i;
                evalRes.evalHit = 1'b1;
            end
`ifdef STEP_STRICT_EN
            LANE_LOCKED: begin
                evalRes.evalNow = win_close_i;
                evalRes.evalHit = 1'b0;
            end
`endif
            default: begin
                evalRes = '0;
            end
        endcase
    end

    // Next-state and counter update; a closing window takes priority over steps.
    always_comb begin
        state_d  = state_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        score_d  = score_q;
        streak_d = streak_q;

        case (state_q)
            LANE_IDLE: begin
                if (win_open_i) begin
                    state_d = LANE_ARMED;
                end
            end
            LANE_ARMED: begin
                if (!win_close_i) begin
                    if (stepMatch) begin
                        state_d = LANE_MATCHED;
                    end
`ifdef STEP_STRICT_EN
                    else if (step_valid_i) begin
                        state_d = LANE_LOCKED;
                    end
`endif
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (evalRes.evalNow) begin
            // A simultaneous open starts the next window straight away.
            state_d = win_open_i ? LANE_ARMED : LANE_IDLE;
            if (evalRes.evalHit) begin
                hit_d    = 1'b1;
                score_d  = (score_q == SCORE_MAX) ? score_q : score_q + 1'b1;
                streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
            end else begin
                miss_d   = 1'b1;
                streak_d = '0;
            end
        end
    end

    // Lane registers; reset discards any open window without a pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= LANE_IDLE;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            score_q  <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            score_q  <= score_d;
            streak_q <= streak_d;
        end
    end

    assign point_o  = (state_q == LANE_MATCHED);
    assign hit_o    = hit_q;
    assign miss_o   = miss_q;
    assign score_o  = score_q;
    assign streak_o = streak_q;

endmodule

// File: rtl/step_scorer.sv
// step_scorer: LANES independent step_lane instances sharing the window
// pulses and expected code. Optional macro STEP_STRICT_EN enables strict lanes.
module step_scorer
    import dance_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int CODE_W   = DEFAULT_CODE_W,
    parameter int SCORE_W  = DEFAULT_SCORE_W,
    parameter int STREAK_W = DEFAULT_STREAK_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      win_open,
    input  logic                      win_close,
    input  logic [CODE_W-1:0]         expected,
    input  logic [LANES*CODE_W-1:0]   step_code,
    input  logic [LANES-1:0]          step_valid,
    output logic [LANES-1:0]          point,
    output logic [LANES-1:0]          hit,
    output logic [LANES-1:0]          miss,
    output logic [LANES*SCORE_W-1:0]  score,
    output logic [LANES*STREAK_W-1:0] streak
);

    // One lane per player, lane 0 in the low slice of every packed bus.
    for (genvar g = 0; g < LANES; g++) begin : gLane
        step_lane #(
            .CODE_W   (CODE_W),
            .SCORE_W  (SCORE_W),
            .STREAK_W (STREAK_W)
        ) uLane (
            .clk_i        (clk),
            .rst_i        (rst),
            .win_open_i   (win_open),
            .win_close_i  (win_close),
            .expected_i   (expected),
            .step_code_i  (step_code[g*CODE_W +: CODE_W]),
            .step_valid_i (step_valid[g]),
            .point_o      (point[g]),
            .hit_o        (hit[g]),
            .miss_o       (miss[g]),
            .score_o      (score[g*SCORE_W +: SCORE_W]),
            .streak_o     (streak[g*STREAK_W +: STREAK_W])
        );
    end

endmodule

// File: tb/tb_step_scorer.sv
// tb_step_scorer: directed scenarios followed by random windows, compared
// against a window-level model of the scoring rules.
module tb_step_scorer;

    localparam int LANES      = 2;
    localparam int CODE_W     = 3;
    localparam int SCORE_W    = 8;
    localparam int STREAK_W   = 4;
    localparam int SCORE_MAX  = (1 << SCORE_W) - 1;
    localparam int STREAK_MAX = (1 << STREAK_W) - 1;

    logic                      clk;
    logic                      rst;
    logic                      winOpen;
    logic                      winClose;
    logic [CODE_W-1:0]         expected;
    logic [LANES*CODE_W-1:0]   stepCode;
    logic [LANES-1:0]          stepValid;
    logic [LANES-1:0]          point;
    logic [LANES-1:0]          hit;
    logic [LANES-1:0]          miss;
    logic [LANES*SCORE_W-1:0]  score;
    logic [LANES*STREAK_W-1:0] streak;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    // Model: per lane, is a window live, has the player already nailed it,
    // has a wrong step forfeited it, and the running totals.
    bit windowLive [LANES];
    bit gotIt      [LANES];
    bit forfeited  [LANES];
    bit wantHit    [LANES];
    bit wantMiss   [LANES];
    int wantScore  [LANES];
    int wantStreak [LANES];

    step_scorer #(
        .LANES    (LANES),
        .CODE_W   (CODE_W),
        .SCORE_W  (SCORE_W),
        .STREAK_W (STREAK_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .win_open   (winOpen),
        .win_close  (winClose),
        .expected   (expected),
        .step_code  (stepCode),
        .step_valid (stepValid),
        .point      (point),
        .hit        (hit),
        .miss       (miss),
        .score      (score),
        .streak     (streak)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] laneScore(input int l);
        return 32'(score[l*SCORE_W +: SCORE_W]);
    endfunction

    function automatic logic [31:0] laneStreak(input int l);
        return 32'(streak[l*STREAK_W +: STREAK_W]);
    endfunction

    task automatic checkOne(input string tag, input int lane,
                            input logic [31:0] observed, input logic [31:0] want);
        checkCount++;
        assert (observed === want) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s lane%0d observed=%0d expected=%0d", tag, lane, observed, want);
        end
    endtask

    // Advance the model by one clock using the inputs sampled at that edge.
    task automatic modelStep();
        int  code;
        bit  valid;
        bit  rightStep;
        for (int l = 0; l < LANES; l++) begin
            code      = int'((stepCode >> (l*CODE_W)) & ((1 << CODE_W) - 1));
            valid     = stepValid[l];
            rightStep = valid && (code == int'(expected));
            wantHit[l]  = 1'b0;
            wantMiss[l] = 1'b0;
            if (rst) begin
                windowLive[l] = 1'b0;
                gotIt[l]      = 1'b0;
                forfeited[l]  = 1'b0;
                wantScore[l]  = 0;
                wantStreak[l] = 0;
            end else if (windowLive[l]) begin
                if (winClose) begin
                    if (gotIt[l] || (!forfeited[l] && rightStep)) begin
                        wantHit[l]    = 1'b1;
                        wantScore[l]  = (wantScore[l] < SCORE_MAX) ? wantScore[l] + 1 : SCORE_MAX;
                        wantStreak[l] = (wantStreak[l] < STREAK_MAX) ? wantStreak[l] + 1 : STREAK_MAX;
                    end else begin
                        wantMiss[l]   = 1'b1;
                        wantStreak[l] = 0;
                    end
                    windowLive[l] = winOpen;
                    gotIt[l]      = 1'b0;
                    forfeited[l]  = 1'b0;
                end else if (!gotIt[l] && !forfeited[l]) begin
                    if (rightStep) gotIt[l] = 1'b1;
`ifdef STEP_STRICT_EN
                    else if (valid) forfeited[l] = 1'b1;
`endif
                end
            end else if (winOpen) begin
                windowLive[l] = 1'b1;
            end
        end
    endtask

    task automatic checkOutput();
        for (int l = 0; l < LANES; l++) begin
            checkOne("point",  l, 32'(point[l]), 32'(gotIt[l]));
            checkOne("hit",    l, 32'(hit[l]),   32'(wantHit[l]));
            checkOne("miss",   l, 32'(miss[l]),  32'(wantMiss[l]));
            checkOne("score",  l, laneScore(l),  32'(wantScore[l]));
            checkOne("streak", l, laneStreak(l), 32'(wantStreak[l]));
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model and compare.
    task automatic applyStimulus(input bit open, input bit close,
                                 input logic [CODE_W-1:0] exp,
                                 input logic [LANES*CODE_W-1:0] codes,
                                 input logic [LANES-1:0] valid,
                                 input bit doReset);
        winOpen   = open;
        winClose  = close;
        expected  = exp;
        stepCode  = codes;
        stepValid = valid;
        rst       = doReset;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic hitWindowLane0();
        applyStimulus(1, 0, 3'd5, 6'b000_000, 2'b00, 0);
        applyStimulus(0, 0, 3'd5, 6'b101_101, 2'b11, 0);
        applyStimulus(0, 1, 3'd5, 6'b000_000, 2'b00, 0);
    endtask

    initial begin
        winOpen = 0; winClose = 0; expected = '0; stepCode = '0; stepValid = '0; rst = 1;

        // Reset state
        applyStimulus(0, 0, 3'd0, '0, '0, 1);
        applyStimulus(0, 0, 3'd0, '0, '0, 1);
        checkOne("reset_score0", 0, laneScore(0), 0);
        checkOne("reset_point",  0, 32'(point), 0);

        // Single match on lane 0
        applyStimulus(1, 0, 3'd5, 6'b000_000, 2'b00, 0);
        applyStimulus(0, 0, 3'd5, 6'b000_101, 2'b01, 0);
        checkOne("req036_point", 0, 32'(point[0]), 1);
        applyStimulus(0, 1, 3'd5, 6'b000_000, 2'b00, 0);
        checkOne("req036_hit",    0, 32'(hit[0]), 1);
        checkOne("req036_score",  0, laneScore(0), 1);
        checkOne("req036_streak", 0, laneStreak(0), 1);

        // Wrong step then right step on lane 1
        applyStimulus(1, 0, 3'd5, 6'b000_000, 2'b00, 0);
        applyStimulus(0, 0, 3'd5, 6'b010_000, 2'b10, 0);
        applyStimulus(0, 0, 3'd5, 6'b101_000, 2'b10, 0);
        applyStimulus(0, 1, 3'd5, 6'b000_000, 2'b00, 0);
`ifdef STEP_STRICT_EN
        checkOne("req037_miss",   1, 32'(miss[1]), 1);
        checkOne("req037_streak", 1, laneStreak(1), 0);
`else
        checkOne("req037_hit",    1, 32'(hit[1]), 1);
        checkOne("req037_score",  1, laneScore(1), 1);
`endif

        // Match, close and reopen all in one cycle
        applyStimulus(1, 0, 3'd5, 6'b000_000, 2'b00, 0);
        applyStimulus(1, 1, 3'd5, 6'b000_101, 2'b01, 0);
        checkOne("req039_hit",   0, 32'(hit[0]), 1);
        checkOne("req039_point", 0, 32'(point[0]), 0);
        applyStimulus(0, 1, 3'd5, 6'b000_000, 2'b00, 0);
        checkOne("req039_rearmed_miss", 0, 32'(miss[0]), 1);

        // Close with nothing open
        applyStimulus(0, 1, 3'd5, 6'b101_101, 2'b11, 0);
        checkOne("req041_hit",  0, 32'(hit), 0);
        checkOne("req041_miss", 0, 32'(miss), 0);

        // Saturation of both counters
        for (int i = 0; i < 260; i++) hitWindowLane0();
        checkOne("req038_score",  0, laneScore(0), 255);
        checkOne("req038_streak", 0, laneStreak(0), 15);
        hitWindowLane0();
        checkOne("req038_score_hold",  0, laneScore(0), 255);
        checkOne("req038_streak_hold", 0, laneStreak(0), 15);

        // Reset while matched
        applyStimulus(0, 0, 3'd0, '0, '0, 1);
        for (int i = 0; i < 7; i++) hitWindowLane0();
        checkOne("req040_pre_score", 0, laneScore(0), 7);
        applyStimulus(1, 0, 3'd5, 6'b000_000, 2'b00, 0);
        applyStimulus(0, 0, 3'd5, 6'b000_101, 2'b01, 0);
        checkOne("req040_pre_point", 0, 32'(point[0]), 1);
        applyStimulus(0, 1, 3'd5, 6'b000_101, 2'b01, 1);
        checkOne("req040_hit",   0, 32'(hit[0]), 0);
        checkOne("req040_score", 0, laneScore(0), 0);
        checkOne("req040_point", 0, 32'(point[0]), 0);

        // Random windows with a narrow code range so matches are frequent
        for (int i = 0; i < 800; i++) begin
            logic [LANES*CODE_W-1:0] codes;
            for (int l = 0; l < LANES; l++) codes[l*CODE_W +: CODE_W] = CODE_W'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0,
                          CODE_W'($urandom_range(0, 3)),
                          codes,
                          LANES'($urandom),
                          $urandom_range(0, 99) == 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
